// File: rtl/fifo_pack_pkg.sv
// Shared types and defaults for the FIFO read-side word packer.
package fifo_pack_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } pack_state_e;

  localparam int BYTES_DEF   = 4;
  localparam int TIMEOUT_DEF = 64;

  // Low cnt bits set; cnt ranges 0..8.
  function automatic logic [7:0] keep_mask(input logic [3:0] cnt);
    return 8'((9'd1 << cnt) - 9'd1);
  endfunction

endpackage

// File: rtl/fifo_pack_idle_timer.sv
// Idle counter for the packer's auto-flush: asserts expired in the cycle the
// run count reaches TIMEOUT. Used only when FIFO_PACK_TIMEOUT_EN is defined.
module fifo_pack_idle_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tcnt <= '0;
    end else if (run && tcnt != TW'(TIMEOUT)) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign expired = run && !clr && (tcnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/fifo_word_packer.sv
// Pops bytes from a show-ahead FIFO and packs BYTES of them little-endian into
// a valid/ready word stream. Optional idle auto-flush via FIFO_PACK_TIMEOUT_EN.
module fifo_word_packer
  import fifo_pack_pkg::*;
#(
  parameter int BYTES   = BYTES_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [7:0]           fifo_rdata,
  output logic                 fifo_rinc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*BYTES-1:0]   out_data,
  output logic [BYTES-1:0]     out_keep,
  output logic                 busy
);

  localparam int CW = $clog2(BYTES + 1);
  localparam int DW = 8 * BYTES;

  if (BYTES < 2 || BYTES > 8) begin : g_bad_bytes
    $error("fifo_word_packer: BYTES must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fifo_word_packer: TIMEOUT must be >= 1");
  end

  pack_state_e       state;
  logic [CW-1:0]     cnt;
  logic [DW-1:0]     acc;
  logic [CW-1:0]     widx;
  logic [BYTES-1:0]  keep_now;
  logic [DW-1:0]     data_mask;
  logic              out_free;
  logic              transfer;
  logic              pop;
  logic              timeout_hit;

  assign out_free = !out_valid || out_ready;
  assign transfer = out_free && ((cnt == CW'(BYTES)) || (state == FLUSH && cnt != '0));
  // Gated by rst so no FIFO byte is consumed and then discarded during reset.
  assign pop      = !rst && (state == FILL) && !fifo_empty &&
                    ((cnt < CW'(BYTES)) || transfer);
  assign fifo_rinc = pop;
  assign busy      = (cnt != '0) || out_valid || (state == FLUSH);

  // A pop in a transfer cycle starts the next word at byte 0.
  assign widx     = transfer ? '0 : cnt;
  assign keep_now = BYTES'(keep_mask(4'(cnt)));

  // Bytes beyond cnt may hold stale data; they are zeroed on the way out.
  always_comb begin
    data_mask = '0;
    for (int i = 0; i < BYTES; i++) begin
      data_mask[8*i +: 8] = {8{keep_now[i]}};
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      acc[8*widx +: 8] <= fifo_rdata;
    end
  end

`ifdef FIFO_PACK_TIMEOUT_EN
  logic tmr_run;
  logic tmr_clr;

  assign tmr_run = (state == FILL) && (cnt != '0) && fifo_empty;
  assign tmr_clr = pop || (cnt == '0);

  fifo_pack_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (tmr_run),
    .clr     (tmr_clr),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
    end else begin
      if (transfer) begin
        out_valid <= 1'b1;
        out_data  <= acc & data_mask;
        out_keep  <= keep_now;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (transfer) begin
        cnt <= pop ? CW'(1) : '0;
      end else if (pop) begin
        cnt <= cnt + 1'b1;
      end

      case (state)
        FILL: begin
          if (flush || timeout_hit) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (cnt == '0 || transfer) begin
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
